// File: rtl/queue_arb_pkg.sv
// Shared definitions for the queue enqueue arbiter: FSM state encodings and
// width helpers used to size index and counter fields from parameters.
package queue_arb_pkg;

    // Arbitration state encodings (the burst state is only used when
    // QARB_BURST_EN is defined).
    localparam logic [0:0] ST_ARB   = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    // Bits needed to index 0..n-1, never less than one.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to hold a count 0..n inclusive.
    function automatic int count_width(input int n);
        return (n > 0) ? $clog2(n + 1) : 1;
    endfunction

endpackage

// File: rtl/queue_enq_arbiter_rr_pick.sv
// rr_pick: combinational round-robin search. Starting at ptr and wrapping
// modulo NREQ, returns the first asserted request as a one-hot vector and an
// index, plus a flag saying whether anything was found.
module rr_pick
    import queue_arb_pkg::*;
#(
    parameter int   NREQ = 4,
    localparam int  IW   = idx_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx,
    output logic            any
);

    logic [IW-1:0] pos;

    // Walk the requesters from ptr upward and latch onto the first one set.
    always_comb begin
        // NOTE: every output of a combinational block gets a default before
        // any conditional assignment, otherwise synthesis infers a latch.
        onehot = '0;
        idx    = '0;
        any    = 1'b0;
        pos    = '0;
        for (int k = 0; k < NREQ; k++) begin
            pos = IW'((int'(ptr) + k) % NREQ);
            if (!any && req[pos]) begin
                any         = 1'b1;
                idx         = pos;
                onehot[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/queue_enq_arbiter.sv
// queue_enq_arbiter: round-robin sharing of a single queue enqueue port among
// NREQ valid/ready producers, with a shadow occupancy counter and an
// almost_full indication for upstream flow control.
// Optional feature: define QARB_BURST_EN to let a winner keep the port for up
// to BURST_LEN consecutive beats before the pointer moves on.
module queue_enq_arbiter
    import queue_arb_pkg::*;
#(
    parameter int   NREQ      = 4,
    parameter int   DWIDTH    = 32,
    parameter int   Q_DEPTH   = 8,
    parameter int   AF_THRESH = 6,
    parameter int   BURST_LEN = 4,
    localparam int  IW        = idx_width(NREQ),
    localparam int  OW        = count_width(Q_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   arb_en,
    input  logic [NREQ-1:0]        req_valid,
    input  logic [NREQ*DWIDTH-1:0] req_data,
    output logic [NREQ-1:0]        req_ready,
    output logic                   q_enq,
    output logic [DWIDTH-1:0]      q_din,
    input  logic                   q_full,
    input  logic                   q_deq,
    output logic [OW-1:0]          occupancy,
    output logic                   almost_full,
    output logic [IW-1:0]          last_grant
);

    // Reject configurations the counters and pointer logic are not sized for.
    if (NREQ < 2 || NREQ > 8 || BURST_LEN < 1 || AF_THRESH > Q_DEPTH) begin : g_param_check
        $error("queue_enq_arbiter: unsupported parameter combination");
    end

    logic [IW-1:0]   rr_ptr;
    logic [NREQ-1:0] eligible;
    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic            pick_any;
    logic            grant_en;
    logic            occ_inc;
    logic            occ_dec;

    // Pointer value just past index i, wrapping at NREQ.
    function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
        return (i == IW'(NREQ - 1)) ? '0 : i + 1'b1;
    endfunction

    // Grants are also held off while in reset so no producer sees ready
    // from a block whose state is being cleared.
    assign grant_en = rstn & arb_en & ~q_full;

`ifdef QARB_BURST_EN
    localparam int BW = count_width(BURST_LEN);

    logic [0:0]    state;
    logic [IW-1:0] burst_idx;
    logic [BW-1:0] burst_cnt;

    // While bursting only the current owner may be granted.
    always_comb begin
        eligible = req_valid;
        if (state == ST_BURST) begin
            eligible = req_valid & (NREQ'(1) << burst_idx);
        end
    end
`else
    assign eligible = req_valid;
`endif

    rr_pick #(
        .NREQ (NREQ)
    ) u_rr_pick (
        .req    (eligible),
        .ptr    (rr_ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign req_ready = grant_en ? pick_onehot : '0;
    assign q_enq     = grant_en & pick_any;

    // Route the granted producer's data to the queue; zero when idle.
    always_comb begin
        q_din = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (req_ready[i]) begin
                q_din = q_din | req_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

`ifdef QARB_BURST_EN
    // Pointer, last grant and burst tracking; the pointer only moves when
    // a burst ends (length reached, owner drops valid, or arb_en removed).
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples values from before the clock edge.
        if (!rstn) begin
            rr_ptr     <= '0;
            last_grant <= '0;
            state      <= ST_ARB;
            burst_idx  <= '0;
            burst_cnt  <= '0;
        end else begin
            if (q_enq) begin
                last_grant <= pick_idx;
            end
            if (state == ST_ARB) begin
                if (q_enq) begin
                    if (BURST_LEN > 1) begin
                        state     <= ST_BURST;
                        burst_idx <= pick_idx;
                        burst_cnt <= BW'(1);
                    end else begin
                        rr_ptr <= next_idx(pick_idx);
                    end
                end
            end else begin
                if (!arb_en || !req_valid[burst_idx]) begin
                    state     <= ST_ARB;
                    burst_cnt <= '0;
                    rr_ptr    <= next_idx(burst_idx);
                end else if (q_enq) begin
                    if (burst_cnt == BW'(BURST_LEN - 1)) begin
                        state     <= ST_ARB;
                        burst_cnt <= '0;
                        rr_ptr    <= next_idx(burst_idx);
                    end else begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                // q_full with valid held: stay in the burst, count unchanged.
            end
        end
    end
`else
    // Every transfer records the winner and moves the pointer past it.
    always_ff @(posedge clk or negedge rstn) begin
        // NOTE: sequential state is updated with non-blocking assignments so
        // every flop samples values from before the clock edge.
        if (!rstn) begin
            rr_ptr     <= '0;
            last_grant <= '0;
        end else if (q_enq) begin
            last_grant <= pick_idx;
            rr_ptr     <= next_idx(pick_idx);
        end
    end
`endif

    // Shadow occupancy: enqueues count up, dequeues count down, and the
    // counter holds at 0 and Q_DEPTH instead of wrapping.
    assign occ_inc = q_enq;
    assign occ_dec = q_deq & (occupancy != '0);

    // Occupancy counter update.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            occupancy <= '0;
        end else if (occ_inc && !occ_dec) begin
            if (occupancy != OW'(Q_DEPTH)) begin
                occupancy <= occupancy + 1'b1;
            end
        end else if (occ_dec && !occ_inc) begin
            occupancy <= occupancy - 1'b1;
        end
    end

    assign almost_full = (occupancy >= OW'(AF_THRESH));

endmodule

// File: tb/tb_queue_enq_arbiter.sv
// Testbench for queue_enq_arbiter. Expected grant indices are queued by the
// stimulus process; a negedge monitor pops one per presented beat and checks
// req_ready and q_din. Occupancy, almost_full and last_grant are checked
// directly from the stimulus process against hand-computed values.
module tb_queue_enq_arbiter;

    localparam int NREQ   = 4;
    localparam int DWIDTH = 32;

    logic                   clk = 1'b0;
    logic                   rstn;
    logic                   arb_en;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DWIDTH-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   q_enq;
    logic [DWIDTH-1:0]      q_din;
    logic                   q_full;
    logic                   q_deq;
    logic [3:0]             occupancy;
    logic                   almost_full;
    logic [1:0]             last_grant;

    int n_checks = 0;
    int n_errors = 0;
    int exp_q[$];

    always #5 clk = ~clk;

    queue_enq_arbiter #(
        .NREQ      (4),
        .DWIDTH    (32),
        .Q_DEPTH   (8),
        .AF_THRESH (6),
        .BURST_LEN (4)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .arb_en      (arb_en),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .q_enq       (q_enq),
        .q_din       (q_din),
        .q_full      (q_full),
        .q_deq       (q_deq),
        .occupancy   (occupancy),
        .almost_full (almost_full),
        .last_grant  (last_grant)
    );

    function automatic logic [31:0] data_of(input int i);
        return 32'hC0DE_0000 | 32'((i + 1) * 'h111);
    endfunction

    task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid_cycle();
        @(negedge clk);
        #1;
    endtask

    // Monitor: every presented beat must match the oldest expected grant.
    always @(negedge clk) begin
        if (rstn) begin
            if (q_enq) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_beat", 64'(req_ready), 64'd0);
                end else begin
                    automatic int e = exp_q.pop_front();
                    check("beat_ready", 64'(req_ready), 64'(1 << e));
                    check("beat_data", 64'(q_din), 64'(data_of(e)));
                end
            end else begin
                check("idle_outputs", {28'd0, req_ready, q_din}, 64'd0);
            end
        end
    end

    // Watchdog: the directed sequence is far shorter than this.
    initial begin
        #50000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    logic [3:0] burst_vec [13];
    int         burst_exp [$];

    initial begin
        rstn      = 1'b0;
        arb_en    = 1'b0;
        req_valid = '0;
        q_full    = 1'b0;
        q_deq     = 1'b0;
        for (int i = 0; i < NREQ; i++) req_data[i*DWIDTH +: DWIDTH] = data_of(i);

        // Reset values.
        #12;
        check("rst_ready", 64'(req_ready), 64'd0);
        check("rst_enq", 64'(q_enq), 64'd0);
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_af", 64'(almost_full), 64'd0);
        check("rst_last", 64'(last_grant), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        next_cycle();

        // All valid for 8 cycles: grants 0,1,2,3,0,1,2,3.
        arb_en    = 1'b1;
        req_valid = 4'hF;
        for (int k = 0; k < 8; k++) exp_q.push_back(k % 4);
        for (int k = 0; k < 8; k++) begin
            mid_cycle();
            check("rr_occ", 64'(occupancy), 64'(k));
            check("rr_af", 64'(almost_full), 64'(k >= 6));
            next_cycle();
        end

        // Full queue blocks grants.
        q_full = 1'b1;
        mid_cycle();
        check("full_occ", 64'(occupancy), 64'd8);
        check("full_af", 64'(almost_full), 64'd1);
        check("full_ready", 64'(req_ready), 64'd0);
        next_cycle();

        // Enqueue and dequeue together: occupancy stays at 8.
        q_full = 1'b0;
        q_deq  = 1'b1;
        exp_q.push_back(0);
        mid_cycle();
        next_cycle();

        // Enqueue with no dequeue at 8: counter saturates.
        req_valid = 4'b0110;
        q_deq     = 1'b0;
        exp_q.push_back(1);
        mid_cycle();
        check("simul_occ", 64'(occupancy), 64'd8);
        next_cycle();

        req_valid = 4'b0110;
        q_deq     = 1'b1;
        exp_q.push_back(2);
        mid_cycle();
        check("sat_occ", 64'(occupancy), 64'd8);
        next_cycle();

        // rr_ptr=3, only req 1 valid: wrap search grants 1.
        req_valid = 4'b0010;
        exp_q.push_back(1);
        mid_cycle();
        check("pre_wrap_last", 64'(last_grant), 64'd2);
        next_cycle();

        // rr_ptr is now 2, so all-valid grants 2.
        req_valid = 4'hF;
        exp_q.push_back(2);
        mid_cycle();
        check("wrap_last", 64'(last_grant), 64'd1);
        next_cycle();

        // Arbitration disabled: no grants, occupancy drains and holds at 0.
        arb_en = 1'b0;
        for (int j = 0; j < 11; j++) begin
            automatic int occ_exp = (8 - j > 0) ? 8 - j : 0;
            mid_cycle();
            check("drain_occ", 64'(occupancy), 64'(occ_exp));
            check("drain_af", 64'(almost_full), 64'(occ_exp >= 6));
            next_cycle();
        end

        // Two beats (3 then 0), then reset in the middle of the next cycle.
        arb_en = 1'b1;
        q_deq  = 1'b0;
        exp_q.push_back(3);
        exp_q.push_back(0);
        mid_cycle();
        next_cycle();
        mid_cycle();
        check("pre_rst_occ", 64'(occupancy), 64'd1);
        next_cycle();
        #1;
        rstn = 1'b0;
        #1;
        check("midrst_ready", 64'(req_ready), 64'd0);
        check("midrst_enq", 64'(q_enq), 64'd0);
        check("midrst_occ", 64'(occupancy), 64'd0);
        check("midrst_last", 64'(last_grant), 64'd0);
        req_valid = '0;
        mid_cycle();
        rstn = 1'b1;
        next_cycle();

        // Pointer restarted at 0 after reset.
        req_valid = 4'hF;
        exp_q.push_back(0);
        mid_cycle();
        next_cycle();
        req_valid = '0;
        #1;
        rstn = 1'b0;
        #1;
        rstn = 1'b1;
        next_cycle();

        // Requesters 0 and 2; requester 0 drops valid partway through.
        burst_vec = '{4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5, 4'h5,
                      4'h4, 4'h4, 4'h0};
`ifdef QARB_BURST_EN
        burst_exp = '{0, 0, 0, 0, 2, 2, 2, 2, 0, 0, 2};
`else
        burst_exp = '{0, 2, 0, 2, 0, 2, 0, 2, 0, 2, 2, 2};
`endif
        foreach (burst_exp[i]) exp_q.push_back(burst_exp[i]);
        for (int c = 0; c < 13; c++) begin
            req_valid = burst_vec[c];
            mid_cycle();
            next_cycle();
        end
        req_valid = '0;

        mid_cycle();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
